// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/result handshake and ALU16 datapath port bundle
interface alu_seq_ctrl_if;
  logic        start, sub, busy, done, alu_bnegate, alu_cin, alu_carry;
  logic [2:0]  op, alu_op;
  logic [15:0] a, b, result, alu_a, alu_b, alu_result;
  modport master (output start, op, sub, a, b, alu_result, alu_carry,
                  input busy, done, result, alu_a, alu_b, alu_op, alu_bnegate, alu_cin);
  modport slave (input start, op, sub, a, b, alu_result, alu_carry,
                 output busy, done, result, alu_a, alu_b, alu_op, alu_bnegate, alu_cin);
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer driving an external ALU16 for single-cycle ops and iterative shifts; ALU_SEQ_EARLY_EXIT_EN ends shifts once work saturates
module alu_seq_ctrl (
  input logic clk,
  input logic rst,
  alu_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
  state_t state, state_nxt;
  logic [2:0] op;
  logic sub, last, exec, shl, neg, ovf, unused;
  logic [15:0] a, b, work, shifted, work_nxt;
  logic [3:0] cnt;
  assign unused = bus.alu_carry;
  assign exec = state == EXEC;
  assign shl = state == SHIFT && op == 3'b111;
  assign neg = exec && (op == 3'b001 || (op == 3'b100 && sub));
  assign bus.busy = state != IDLE;
  assign bus.alu_a = exec ? a : shl ? work : '0;
  assign bus.alu_b = exec ? b : shl ? work : '0;
  assign bus.alu_op = (neg || shl || (exec && op == 3'b101)) ? 3'b100 : exec ? op : 3'b000;
  assign bus.alu_bnegate = neg;
  assign bus.alu_cin = neg;
  // next state, shift step and termination decision
  always_comb begin
    shifted = op == 3'b111 ? bus.alu_result : {work[15], work[15:1]};
    work_nxt = cnt == 4'd0 ? work : shifted;
    ovf = (a[15] ^ b[15]) & (a[15] ^ bus.alu_result[15]);
`ifdef ALU_SEQ_EARLY_EXIT_EN
    last = cnt <= 4'd1 || work_nxt == 16'h0000 || (op == 3'b110 && work_nxt == 16'hffff);
`else
    last = cnt <= 4'd1;
`endif
    state_nxt = state == IDLE ? (bus.start ? (bus.op[2:1] == 2'b11 ? SHIFT : EXEC) : IDLE) :
                state == EXEC ? IDLE : (last ? IDLE : SHIFT);
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  // operand latch, shift iteration, result capture and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0;
      sub <= 1'b0;
      a <= '0;
      b <= '0;
      work <= '0;
      cnt <= '0;
      bus.result <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= exec || (state == SHIFT && last);
      if (state == IDLE && bus.start) begin
        op <= bus.op;
        sub <= bus.sub;
        a <= bus.a;
        b <= bus.b;
        work <= bus.a;
        cnt <= bus.b[3:0];
      end
      if (state == SHIFT) begin
        work <= work_nxt;
        cnt <= cnt - 4'd1;
      end
      if (exec)
        bus.result <= op == 3'b001 ? {15'b0, bus.alu_result[15] ^ ovf} : bus.alu_result;
      if (state == SHIFT && last)
        bus.result <= work_nxt;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for alu_seq_ctrl with a behavioural ALU16
module tb_alu_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, fails = 0, t_lat = 0;
  logic [15:0] bneg;
  logic [16:0] sum;
  typedef struct {logic [15:0] res; int lat; string tag;} exp_t;
  exp_t sb[$];
  alu_seq_ctrl_if bus();
  alu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // ALU16 datapath model
  always_comb begin
    bneg = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
    sum = {1'b0, bus.alu_a} + {1'b0, bneg} + {16'b0, bus.alu_cin};
    bus.alu_result = bus.alu_op == 3'd0 ? (bus.alu_a & bneg) :
                     bus.alu_op == 3'd2 ? (bus.alu_a | bneg) :
                     bus.alu_op == 3'd3 ? (bus.alu_a ^ bneg) :
                     bus.alu_op == 3'd4 ? sum[15:0] : 16'h0000;
    bus.alu_carry = sum[16];
  end
  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [2:0] op, input logic sub, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input int lat, input string tag);
    exp_t e;
    e.res = res;
    e.lat = lat;
    e.tag = tag;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op = op;
    bus.sub = sub;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t_lat = 1;
  endtask
  task automatic finish_op();
    exp_t e;
    while (bus.done !== 1'b1 && t_lat < 60) begin
      @(posedge clk);
      #1;
      t_lat++;
    end
    e = sb.pop_front();
    chk({15'b0, bus.done}, 16'h0001, {e.tag, "_done"});
    chk(bus.result, e.res, {e.tag, "_result"});
    chk(16'(t_lat), 16'(e.lat), {e.tag, "_latency"});
  endtask
  initial begin
    logic seen;
    bus.start = 1'b0;
    bus.op = '0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(bus.result, 16'h0000, "rst_result");
    chk({14'b0, bus.busy, bus.done}, 16'h0000, "rst_busy_done");
    chk(bus.alu_a | bus.alu_b, 16'h0000, "rst_alu_ab");
    chk({11'b0, bus.alu_op, bus.alu_bnegate, bus.alu_cin}, 16'h0000, "rst_alu_ctl");
    launch(3'b100, 1'b0, 16'h1234, 16'h0f0f, 16'h2143, 2, "add");
    chk({15'b0, bus.busy}, 16'h0001, "add_busy");
    finish_op();
    launch(3'b100, 1'b1, 16'h0005, 16'h0007, 16'hfffe, 2, "sub");
    chk({11'b0, bus.alu_op, bus.alu_bnegate, bus.alu_cin}, 16'b10011, "sub_alu_ctl");
    finish_op();
    chk(bus.alu_a | bus.alu_b, 16'h0000, "idle_alu_ab");
    launch(3'b001, 1'b0, 16'h8000, 16'h0001, 16'h0001, 2, "slt_ovf");
    finish_op();
    launch(3'b001, 1'b0, 16'h0001, 16'h8000, 16'h0000, 2, "slt_neg");
    finish_op();
    launch(3'b000, 1'b0, 16'hf0f0, 16'h3c3c, 16'h3030, 2, "and");
    finish_op();
    launch(3'b010, 1'b0, 16'hf0f0, 16'h3c3c, 16'hfcfc, 2, "or");
    finish_op();
    launch(3'b011, 1'b0, 16'hf0f0, 16'h3c3c, 16'hcccc, 2, "xor");
    finish_op();
    launch(3'b101, 1'b1, 16'h0010, 16'hfffe, 16'h000e, 2, "addi");
    chk({13'b0, bus.alu_op}, 16'h0004, "addi_aluop");
    finish_op();
    launch(3'b111, 1'b0, 16'h0003, 16'h0004, 16'h0030, 5, "sll4");
    bus.start = 1'b1;
    bus.op = 3'b000;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t_lat++;
    finish_op();
    launch(3'b111, 1'b0, 16'h0003, 16'h0000, 16'h0003, 2, "sll0");
    finish_op();
    launch(3'b111, 1'b0, 16'h8001, 16'hfff1, 16'h0002, 2, "sll_hi_b");
    finish_op();
`ifdef ALU_SEQ_EARLY_EXIT_EN
    launch(3'b110, 1'b0, 16'hf000, 16'h000f, 16'hffff, 13, "sra15");
`else
    launch(3'b110, 1'b0, 16'hf000, 16'h000f, 16'hffff, 16, "sra15");
`endif
    chk(bus.alu_a | bus.alu_b | {13'b0, bus.alu_op}, 16'h0000, "sra_alu_zero");
    finish_op();
    launch(3'b110, 1'b0, 16'h4000, 16'h0003, 16'h0800, 4, "sra3");
    finish_op();
    launch(3'b100, 1'b0, 16'h0001, 16'h0001, 16'h0002, 2, "b2b_first");
    finish_op();
    launch(3'b001, 1'b0, 16'h0005, 16'h0007, 16'h0001, 2, "b2b_second");
    chk({14'b0, bus.busy, bus.done}, 16'b10, "b2b_accepted");
    finish_op();
    bus.start = 1'b1;
    bus.op = 3'b111;
    bus.a = 16'h0003;
    bus.b = 16'h0008;
    @(posedge clk);
    #1;
    bus.op = 3'b000;
    bus.a = 16'hffff;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({15'b0, bus.busy}, 16'h0001, "abort_busy");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({14'b0, bus.busy, bus.done}, 16'h0000, "abort_busy_done");
    chk(bus.result, 16'h0000, "abort_result");
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen |= bus.done;
    end
    chk({15'b0, seen}, 16'h0000, "abort_no_done");
    rst = 1'b1;
    bus.start = 1'b1;
    bus.op = 3'b100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    chk({15'b0, bus.busy}, 16'h0000, "rst_dominates_start");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Clock  in  1  single clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Start  in  1  request pulse; sampled only in IDLE.
REQ-004 Op  in  3  000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD/SUB, 101 ADDI, 110 SRA, 111 SLL.
REQ-005 Sub  in  1  ADD/SUB only: 1 = A-B.
REQ-006 A, B  in  16 each  operands; ADDI B = sign-extended immediate; shifts use B[3:0] as amount n.
REQ-007 Busy  out  1  high in EXEC and SHIFT.
REQ-008 Done  out  1  registered one-cycle completion pulse.
REQ-009 Result  out  16  registered result, held until next completion.
REQ-010 AluA, AluB  out  16 each  operands to the ALU16 datapath.
REQ-011 AluOp  out  3  ALU mux select; AluBnegate, AluCin  out  1 each.
REQ-012 AluResult  in  16  combinational ALU output; AluCarry  in  1 (unused except observability).

Function
REQ-013 States IDLE, EXEC, SHIFT; Start in IDLE latches Op, Sub, A, B (and n) and moves to EXEC (ops 000-101) or SHIFT (110, 111).
REQ-014 Start while Busy is ignored; latched operands do not change.
REQ-015 EXEC lasts exactly one cycle: drive ALU from latched values, capture Result at the cycle end, pulse Done next cycle, return to IDLE.
REQ-016 Non-shift latency: Start sampled at edge k -> Done and valid Result in the cycle after edge k+2.
REQ-017 SUB and SLT drive AluBnegate=1, AluCin=1, AluOp=100; all other EXEC ops drive AluBnegate=0, AluCin=0, AluOp=Op (ADDI -> 100).
REQ-018 SLT: ovf = (A[15] ^ B[15]) & (A[15] ^ AluResult[15]); Result = {15'b0, AluResult[15] ^ ovf}.
REQ-019 SLL: per SHIFT cycle, AluA=AluB=work, AluOp=100, Cin=0; work <= AluResult (one-bit left shift via A+A).
REQ-020 SRA: per SHIFT cycle, work <= {work[15], work[15:1]} internally; ALU outputs held at zero.
REQ-021 SHIFT lasts n cycles for n>0; n=0 takes one SHIFT cycle with no shift, Result=A.
REQ-022 Shift latency: Done asserted in the cycle after edge k+1+max(n,1).
REQ-023 In IDLE, AluA, AluB, AluOp, AluBnegate, AluCin are all zero.
REQ-024 Done is high with state IDLE; Start asserted in the Done cycle is accepted.
REQ-025 B[15:4] is ignored for shifts; no shift exceeds 15 positions.

Reset
REQ-026 Reset forces IDLE; Busy=0, Done=0, Result=0x0000, work and counter cleared, ALU outputs zero.
REQ-027 Reset mid-operation aborts without a Done pulse; Reset dominates a simultaneous Start.

Configuration
REQ-028 Macro ALU_SEQ_EARLY_EXIT_EN defined: SLL ends after the step producing work=0x0000; SRA ends after the step producing 0x0000 or 0xFFFF; Done follows next cycle; Result identical to full run.
REQ-029 Macro undefined: shift latency is always exactly per REQ-022.

Verification
REQ-030 ADD A=0x1234, B=0x0F0F, Sub=0 -> Result 0x2143, Done 2 cycles after Start.
REQ-031 ADD/SUB A=0x0005, B=0x0007, Sub=1 -> 0xFFFE; SLT A=0x8000, B=0x0001 -> 0x0001 (overflow path); SLT A=0x0001, B=0x8000 -> 0x0000.
REQ-032 SLL A=0x0003, n=4 -> 0x0030, Done 5 cycles after Start; n=0 -> 0x0003, Done 2 cycles after Start.
REQ-033 SRA A=0xF000, n=15 -> 0xFFFF; Done 16 cycles after Start without macro, 13 with ALU_SEQ_EARLY_EXIT_EN.
REQ-034 Start during SLL n=8 -> ignored; Reset asserted 3 cycles into it -> no Done, Result 0x0000, Busy 0 next cycle.
REQ-035 Back-to-back: Start held in the Done cycle -> new operation accepted, no idle gap.
